mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares the single data-memory port of the RV32I core among up to four requesters, such as LSU, debug, DMA and fetch-miss.
It drives the select of the 4:1 mux_4x1 instances that steer address, write data and control onto the memory port.
It sequences each transaction through issue and response phases, with a response watchdog.
It sits between the requesters and the memory interface in the datapath.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..4; select stays 2 bits to match mux_4x1.
TIMEOUT, 255, maximum number of WAIT cycles before the transaction is aborted; 0 disables the watchdog.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_req  input  NUM_REQ  per-requester request; must be held until o_ack or o_timeout.
o_grant  output  NUM_REQ  one-hot grant; held for the whole transaction.
o_sel  output  2  binary index of the granted requester; drives the mux_4x1 sel inputs.
o_mem_valid  output  1  request valid to the memory port.
i_mem_ready  input  1  memory accepts the request when o_mem_valid=1.
i_mem_rvalid  input  1  memory response/completion strobe.
o_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
o_timeout  output  1  one-cycle pulse when the watchdog aborts a transaction.
o_busy  output  1  high in ISSUE and WAIT.

Behaviour:
- Reset (i_clk edge with i_rst=1, from any state):
  - state=IDLE.
  - o_grant=0, o_sel=0, o_mem_valid=0, o_ack=0, o_timeout=0, o_busy=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter=0.
  - An in-flight transaction is abandoned; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from (rr_ptr+1) mod NUM_REQ with wrap-around.
  - Register o_grant and o_sel, then move to ISSUE.
  - Grant becomes visible the cycle after i_req is sampled.
  - While in IDLE, o_grant=0 and o_sel holds the last granted index, so the mux does not toggle.
- ISSUE:
  - o_mem_valid=1; o_grant and o_sel are stable.
  - i_mem_ready=0: stay in ISSUE indefinitely; the watchdog is not running.
  - i_mem_ready=1 and i_mem_rvalid=0: go to WAIT and clear the counter.
  - i_mem_ready=1 and i_mem_rvalid=1: complete in this cycle (see completion).
- WAIT:
  - o_mem_valid=0; the counter increments each cycle without i_mem_rvalid.
  - i_mem_rvalid=1: completion.
  - TIMEOUT!=0, counter==TIMEOUT-1 and no i_mem_rvalid: o_timeout=1 this cycle, no o_ack, go to IDLE. WAIT therefore lasts at most TIMEOUT cycles.
- Completion:
  - o_ack[g]=1 combinationally in the cycle i_mem_rvalid is sampled (g = granted index).
  - On that edge: rr_ptr<=g and state<=IDLE.
  - Timeout also sets rr_ptr<=g.
- Ignored events:
  - i_mem_rvalid in IDLE, or in ISSUE without i_mem_ready, is ignored.
  - i_mem_ready outside ISSUE is ignored.
- i_req withdrawn mid-transaction: the transaction still completes and the ack/timeout still fires. Requesters must not withdraw.
- Requests for index >= NUM_REQ do not exist; unused o_sel codes are never produced.
- Throughput:
  - One IDLE cycle between transactions is mandatory.
  - Minimum transaction is 2 cycles (IDLE -> ISSUE with ready+rvalid).
  - Typical transaction is 3 cycles.
- Counter width is $clog2(TIMEOUT+1). o_busy = (state!=IDLE).

Test Plan:
1. After reset, i_req=0010; i_mem_ready=1 in the first ISSUE cycle; i_mem_rvalid 2 cycles later -> o_grant=0010 and o_sel=1 from cycle 1, o_mem_valid high for exactly 1 cycle, o_ack=0010 pulse for 1 cycle, then IDLE with o_sel still 1.
2. i_req=1111 held; memory responds with ready and rvalid in the same cycle -> grant order 0,1,2,3,0,1, one grant every 2 cycles.
3. Serve requester 1 (rr_ptr=1), then i_req=0011 -> next grant is requester 0 (search 2, 3, wrap, 0); with i_req=0111 -> requester 2.
4. i_mem_ready held low for 5 ISSUE cycles with i_req=0100 -> o_mem_valid high for 6 cycles, o_sel=2 stable throughout, no watchdog activity, normal ack after rvalid.
5. TIMEOUT=8, i_req=0001, ready given, rvalid never arrives -> o_timeout pulses in the 8th WAIT cycle, o_ack stays 0, and a pending i_req=0010 is granted 2 cycles later.
6. i_rst asserted for 1 cycle while in WAIT with o_grant=1000 -> next cycle all outputs are 0; a late i_mem_rvalid produces no ack; then with i_req=1001 the first grant goes to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared data-memory port.
// Sequences issue/response phases with a response watchdog.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [1:0]         o_sel,
  output logic               o_mem_valid,
  input  logic               i_mem_ready,
  input  logic               i_mem_rvalid,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RR_INIT = 2'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [3:0] req4;
  logic [3:0] onehot;
  logic [2:0] sum;
  logic [1:0] pick;
  logic       found;
  logic       done;
  logic       expire;

  // Search upward from the slot after the last served requester.
  always_comb begin
    req4 = '0;
    req4[NUM_REQ-1:0] = i_req;
    found = 1'b0;
    pick = 2'd0;
    sum = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      if (!found && req4[sum[1:0]]) begin
        found = 1'b1;
        pick = sum[1:0];
      end
    end
    onehot = 4'b0001 << pick;
  end

  assign done = ((state_q == ISSUE) && i_mem_ready && i_mem_rvalid)
             || ((state_q == WAIT) && i_mem_rvalid);

  assign expire = (TIMEOUT != 0) && (state_q == WAIT)
               && !i_mem_rvalid && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = onehot[NUM_REQ-1:0];
          sel_d   = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready && !i_mem_rvalid) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!done && !expire) cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // sel is kept on return to IDLE so the mux does not toggle
    if (done || expire) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = sel_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      rr_q    <= RR_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_sel       = sel_q;
  assign o_mem_valid = (state_q == ISSUE);
  assign o_busy      = (state_q != IDLE);
  assign o_ack       = done ? grant_q : '0;
  assign o_timeout   = expire;

endmodule
